// File: rtl/exec_monitor_pkg.sv
// exec_monitor_pkg: shared FSM state type and default parameters for execution_monitor
package exec_monitor_pkg;
    typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} mon_state_t;
    localparam int DEF_PC_WIDTH       = 16;
    localparam int DEF_STATE_WIDTH    = 3;
    localparam int DEF_FETCH_STATE    = 0;
    localparam int DEF_STALL_CYCLES   = 5;
    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_COUNT_WIDTH    = 32;
endpackage

// File: rtl/execution_monitor_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/execution_monitor.sv
// execution_monitor: watches a CPU's pc/state, gathers run statistics and flags halts or timeouts
module execution_monitor
    import exec_monitor_pkg::*;
#(
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int STATE_WIDTH    = DEF_STATE_WIDTH,
    parameter int FETCH_STATE    = DEF_FETCH_STATE,
    parameter int STALL_CYCLES   = DEF_STALL_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic [STATE_WIDTH-1:0] cpu_state,
    input  logic                   mem_write,
    output logic                   running,
    output logic                   done,
    output logic                   halted,
    output logic                   timed_out,
    output logic [PC_WIDTH-1:0]    halt_pc,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [COUNT_WIDTH-1:0] write_count
);
    mon_state_t             state;
    logic [PC_WIDTH-1:0]    prev_pc;
    logic [STATE_WIDTH-1:0] prev_state;
    logic                   prev_valid;
    logic [7:0]             stall_cnt;
    logic in_run, accept, is_fetch, stall, halt_hit, timeout_hit;

    assign in_run      = state == RUN;
    assign accept      = start && !in_run;
    assign is_fetch    = cpu_state == STATE_WIDTH'(FETCH_STATE);
    assign stall       = in_run && is_fetch && prev_valid && pc == prev_pc;
    assign halt_hit    = stall && stall_cnt == 8'(STALL_CYCLES - 1);
    // compared one ahead so the transition edge is the one where cycle_count reaches the limit
    assign timeout_hit = in_run && (64'(cycle_count) + 64'd1 >= 64'(TIMEOUT_CYCLES));

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            prev_pc    <= '0;
            prev_state <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_pc    <= pc;
            prev_state <= cpu_state;
            prev_valid <= !accept;
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state     <= IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            halted    <= 1'b0;
            timed_out <= 1'b0;
            halt_pc   <= '0;
            stall_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= RUN;
                running   <= 1'b1;
                halted    <= 1'b0;
                timed_out <= 1'b0;
                halt_pc   <= '0;
                stall_cnt <= '0;
            end else if (in_run) begin
                stall_cnt <= stall ? stall_cnt + 8'd1 : 8'd0;
                if (halt_hit) begin
                    state   <= HALTED;
                    running <= 1'b0;
                    halted  <= 1'b1;
                    halt_pc <= pc;
                    done    <= 1'b1;
                end else if (timeout_hit) begin
                    state     <= TIMEOUT;
                    running   <= 1'b0;
                    timed_out <= 1'b1;
                    done      <= 1'b1;
                end
            end
        end

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_cycle (
        .clock(clock), .reset_n(reset_n), .clear(accept), .enable(in_run), .count(cycle_count)
    );
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_instr (
        .clock(clock), .reset_n(reset_n), .clear(accept),
        .enable(in_run && is_fetch && prev_state != STATE_WIDTH'(FETCH_STATE)), .count(instr_count)
    );
    sat_counter #(.WIDTH(COUNT_WIDTH)) u_write (
        .clock(clock), .reset_n(reset_n), .clear(accept), .enable(in_run && mem_write), .count(write_count)
    );
endmodule

// File: tb/tb_execution_monitor.sv
// tb_execution_monitor: directed checks of halt, timeout, tie, reset and saturation behaviour
module tb_execution_monitor;
    localparam logic [2:0] F = 3'd0;
    localparam logic [2:0] D = 3'd1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pc = '0;
    logic [2:0]  cpu_state = D;
    logic        mem_write = 1'b0;
    int tests = 0;
    int failed = 0;

    logic a_running, a_done, a_halted, a_timed_out;
    logic [15:0] a_halt_pc;
    logic [31:0] a_cycle, a_instr, a_wc;
    logic b_running, b_done, b_halted, b_timed_out;
    logic [15:0] b_halt_pc;
    logic [31:0] b_cycle, b_instr, b_wc;
    logic c_running, c_done, c_halted, c_timed_out;
    logic [15:0] c_halt_pc;
    logic [31:0] c_cycle, c_instr, c_wc;
    logic d_running, d_done, d_halted, d_timed_out;
    logic [15:0] d_halt_pc;
    logic [3:0]  d_cycle, d_instr, d_wc;

    always #5 clock = ~clock;

    execution_monitor dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .pc(pc), .cpu_state(cpu_state),
        .mem_write(mem_write), .running(a_running), .done(a_done), .halted(a_halted),
        .timed_out(a_timed_out), .halt_pc(a_halt_pc), .cycle_count(a_cycle),
        .instr_count(a_instr), .write_count(a_wc)
    );
    execution_monitor #(.TIMEOUT_CYCLES(20)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .pc(pc), .cpu_state(cpu_state),
        .mem_write(mem_write), .running(b_running), .done(b_done), .halted(b_halted),
        .timed_out(b_timed_out), .halt_pc(b_halt_pc), .cycle_count(b_cycle),
        .instr_count(b_instr), .write_count(b_wc)
    );
    execution_monitor #(.TIMEOUT_CYCLES(6)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start), .pc(pc), .cpu_state(cpu_state),
        .mem_write(mem_write), .running(c_running), .done(c_done), .halted(c_halted),
        .timed_out(c_timed_out), .halt_pc(c_halt_pc), .cycle_count(c_cycle),
        .instr_count(c_instr), .write_count(c_wc)
    );
    execution_monitor #(.COUNT_WIDTH(4)) dut_d (
        .clock(clock), .reset_n(reset_n), .start(start), .pc(pc), .cpu_state(cpu_state),
        .mem_write(mem_write), .running(d_running), .done(d_done), .halted(d_halted),
        .timed_out(d_timed_out), .halt_pc(d_halt_pc), .cycle_count(d_cycle),
        .instr_count(d_instr), .write_count(d_wc)
    );

    task automatic drive(input logic [15:0] p, input logic [2:0] s, input logic w);
        pc = p;
        cpu_state = s;
        mem_write = w;
        @(negedge clock);
    endtask

    task automatic do_reset();
        start = 1'b0;
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_start();
        start = 1'b1;
        cpu_state = D;
        mem_write = 1'b0;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        tests++;
        if ({a_running, a_done, a_halted, a_timed_out} !== 4'b0 || a_halt_pc !== 16'd0 ||
            a_cycle !== 32'd0 || a_instr !== 32'd0 || a_wc !== 32'd0) begin
            failed++;
            $display("FAIL reset_outputs got run=%b done=%b halt=%b to=%b pc=%0d cyc=%0d ins=%0d wr=%0d expected all 0",
                     a_running, a_done, a_halted, a_timed_out, a_halt_pc, a_cycle, a_instr, a_wc);
        end
        @(negedge clock);
        reset_n = 1'b1;
        drive(16'd5, F, 1'b1);
        drive(16'd5, F, 1'b1);
        tests++;
        if (a_running !== 1'b0 || a_cycle !== 32'd0) begin
            failed++;
            $display("FAIL idle_wait got running=%b cycle=%0d expected 0 0", a_running, a_cycle);
        end
    endtask

    task automatic test_halt_sequence();
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            drive(16'(i), F, 1'b0);
            drive(16'(i), D, 1'b0);
        end
        for (int i = 0; i < 4; i++) drive(16'd3, F, 1'b0);
        tests++;
        if (a_halted !== 1'b0) begin
            failed++;
            $display("FAIL halt_early got halted=%b expected 0", a_halted);
        end
        drive(16'd3, F, 1'b0);
        tests++;
        if (a_halted !== 1'b1 || a_done !== 1'b1 || a_running !== 1'b0 || a_timed_out !== 1'b0) begin
            failed++;
            $display("FAIL halt_status got halted=%b done=%b running=%b timed_out=%b expected 1 1 0 0",
                     a_halted, a_done, a_running, a_timed_out);
        end
        tests++;
        if (a_halt_pc !== 16'd3) begin
            failed++;
            $display("FAIL halt_pc got %0d expected 3", a_halt_pc);
        end
        tests++;
        if (a_cycle !== 32'd13 || a_instr !== 32'd5) begin
            failed++;
            $display("FAIL halt_counts got cycle=%0d instr=%0d expected 13 5", a_cycle, a_instr);
        end
        drive(16'd8, D, 1'b1);
        drive(16'd9, F, 1'b1);
        tests++;
        if (a_done !== 1'b0 || a_cycle !== 32'd13 || a_wc !== 32'd0 || a_halt_pc !== 16'd3) begin
            failed++;
            $display("FAIL halt_hold got done=%b cycle=%0d wc=%0d halt_pc=%0d expected 0 13 0 3",
                     a_done, a_cycle, a_wc, a_halt_pc);
        end
        do_start();
        tests++;
        if (a_running !== 1'b1 || a_halted !== 1'b0 || a_cycle !== 32'd0 || a_halt_pc !== 16'd0) begin
            failed++;
            $display("FAIL restart got running=%b halted=%b cycle=%0d halt_pc=%0d expected 1 0 0 0",
                     a_running, a_halted, a_cycle, a_halt_pc);
        end
    endtask

    task automatic test_stall_count();
        do_reset();
        do_start();
        repeat (5) drive(16'd7, F, 1'b0);
        tests++;
        if (a_halted !== 1'b0 || a_cycle !== 32'd5) begin
            failed++;
            $display("FAIL stall_early got halted=%b cycle=%0d expected 0 5", a_halted, a_cycle);
        end
        drive(16'd7, F, 1'b0);
        tests++;
        if (a_halted !== 1'b1 || a_cycle !== 32'd6 || a_halt_pc !== 16'd7 || a_instr !== 32'd1) begin
            failed++;
            $display("FAIL stall_halt got halted=%b cycle=%0d halt_pc=%0d instr=%0d expected 1 6 7 1",
                     a_halted, a_cycle, a_halt_pc, a_instr);
        end
    endtask

    task automatic test_halt_timeout_tie();
        do_reset();
        do_start();
        repeat (5) drive(16'd2, F, 1'b0);
        tests++;
        if (c_running !== 1'b1 || c_timed_out !== 1'b0) begin
            failed++;
            $display("FAIL tie_early got running=%b timed_out=%b expected 1 0", c_running, c_timed_out);
        end
        drive(16'd2, F, 1'b0);
        tests++;
        if (c_halted !== 1'b1 || c_timed_out !== 1'b0 || c_done !== 1'b1 || c_cycle !== 32'd6) begin
            failed++;
            $display("FAIL tie_result got halted=%b timed_out=%b done=%b cycle=%0d expected 1 0 1 6",
                     c_halted, c_timed_out, c_done, c_cycle);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        do_start();
        for (int i = 0; i < 19; i++) drive(16'(i), F, 1'b0);
        tests++;
        if (b_timed_out !== 1'b0 || b_cycle !== 32'd19) begin
            failed++;
            $display("FAIL timeout_early got timed_out=%b cycle=%0d expected 0 19", b_timed_out, b_cycle);
        end
        drive(16'd19, F, 1'b0);
        tests++;
        if (b_timed_out !== 1'b1 || b_done !== 1'b1 || b_halted !== 1'b0 || b_cycle !== 32'd20) begin
            failed++;
            $display("FAIL timeout_status got timed_out=%b done=%b halted=%b cycle=%0d expected 1 1 0 20",
                     b_timed_out, b_done, b_halted, b_cycle);
        end
        drive(16'd20, F, 1'b0);
        tests++;
        if (b_done !== 1'b0 || b_cycle !== 32'd20) begin
            failed++;
            $display("FAIL timeout_hold got done=%b cycle=%0d expected 0 20", b_done, b_cycle);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        do_start();
        for (int i = 0; i < 14; i++) drive(16'(i), F, 1'b1);
        tests++;
        if (d_wc !== 4'd14) begin
            failed++;
            $display("FAIL sat_before got write_count=%0d expected 14", d_wc);
        end
        for (int i = 14; i < 20; i++) drive(16'(i), F, 1'b1);
        tests++;
        if (d_wc !== 4'd15 || d_cycle !== 4'd15 || d_running !== 1'b1) begin
            failed++;
            $display("FAIL sat_hold got write_count=%0d cycle=%0d running=%b expected 15 15 1",
                     d_wc, d_cycle, d_running);
        end
    endtask

    task automatic test_mid_run_reset();
        do_reset();
        do_start();
        for (int i = 0; i < 3; i++) drive(16'(i), F, 1'b1);
        tests++;
        if (a_running !== 1'b1 || a_wc !== 32'd3) begin
            failed++;
            $display("FAIL midrun_pre got running=%b wc=%0d expected 1 3", a_running, a_wc);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if ({a_running, a_done, a_halted, a_timed_out} !== 4'b0 || a_cycle !== 32'd0 ||
            a_instr !== 32'd0 || a_wc !== 32'd0 || a_halt_pc !== 16'd0) begin
            failed++;
            $display("FAIL midrun_async got run=%b done=%b halt=%b to=%b cyc=%0d ins=%0d wr=%0d expected all 0",
                     a_running, a_done, a_halted, a_timed_out, a_cycle, a_instr, a_wc);
        end
        @(negedge clock);
        reset_n = 1'b1;
        drive(16'd1, F, 1'b0);
        drive(16'd1, F, 1'b0);
        tests++;
        if (a_running !== 1'b0 || a_done !== 1'b0 || a_cycle !== 32'd0) begin
            failed++;
            $display("FAIL midrun_idle got running=%b done=%b cycle=%0d expected 0 0 0", a_running, a_done, a_cycle);
        end
        do_start();
        repeat (6) drive(16'd9, F, 1'b0);
        tests++;
        if (a_halted !== 1'b1 || a_cycle !== 32'd6 || a_halt_pc !== 16'd9) begin
            failed++;
            $display("FAIL midrun_rerun got halted=%b cycle=%0d halt_pc=%0d expected 1 6 9", a_halted, a_cycle, a_halt_pc);
        end
    endtask

    initial begin
        test_reset();
        test_halt_sequence();
        test_stall_count();
        test_halt_timeout_tie();
        test_timeout();
        test_saturation();
        test_mid_run_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/execution_monitor.md
EXECUTION_MONITOR -- requirements
Module: execution_monitor

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 16, width of the monitored program counter.
REQ-002 The block SHALL have parameter STATE_WIDTH, default 3, width of the monitored CPU state.
REQ-003 The block SHALL have parameter FETCH_STATE, default 0, the CPU state value that marks instruction fetch.
REQ-004 The block SHALL have parameter STALL_CYCLES, default 5, the number of consecutive stalled fetch cycles that declares a halt (legal range 1..255).
REQ-005 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, the run-cycle limit (legal range >= 1).
REQ-006 The block SHALL have parameter COUNT_WIDTH, default 32, width of every statistics counter.
REQ-007 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-008 clock  input  1  rising-edge clock for all state.
REQ-009 reset_n  input  1  asynchronous active-low reset.
REQ-010 start  input  1  one-cycle request to begin a monitoring run.
REQ-011 pc  input  PC_WIDTH  current CPU program counter.
REQ-012 cpu_state  input  STATE_WIDTH  current CPU control state.
REQ-013 mem_write  input  1  CPU memory write strobe.
REQ-014 running  output  1  high while in RUN.
REQ-015 done  output  1  one-cycle pulse on entry to HALTED or TIMEOUT.
REQ-016 halted  output  1  sticky, set on halt detection.
REQ-017 timed_out  output  1  sticky, set on timeout.
REQ-018 halt_pc  output  PC_WIDTH  pc value captured at halt detection.
REQ-019 cycle_count, instr_count, write_count  output  COUNT_WIDTH each  run statistics.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, HALTED and TIMEOUT.
REQ-021 On start in IDLE, HALTED or TIMEOUT, the block SHALL enter RUN on the next edge and clear all counters, halted, timed_out, halt_pc and the stall counter; start in RUN SHALL be ignored.
REQ-022 In RUN, cycle_count SHALL increment by 1 every cycle, starting with the first RUN cycle.
REQ-023 In RUN, instr_count SHALL increment on each cycle where cpu_state==FETCH_STATE and the previous-cycle cpu_state!=FETCH_STATE.
REQ-024 In RUN, write_count SHALL increment on each cycle with mem_write=1.
REQ-025 All counters SHALL saturate at all-ones and never wrap.
REQ-026 The block SHALL register pc and cpu_state every cycle, with a valid flag that is cleared on start; on the first RUN cycle the comparison SHALL be invalid and the cycle SHALL not count as a stall.
REQ-027 The stall counter SHALL increment when cpu_state==FETCH_STATE and pc equals the previous pc (valid flag set), and SHALL clear to 0 otherwise.
REQ-028 When the stall counter reaches STALL_CYCLES, the block SHALL enter HALTED on that edge, latch halt_pc=pc, set halted and pulse done.
REQ-029 When cycle_count reaches TIMEOUT_CYCLES, the block SHALL enter TIMEOUT, set timed_out and pulse done.
REQ-030 If halt and timeout qualify in the same cycle, HALTED SHALL win and timed_out SHALL remain 0.
REQ-031 In HALTED and TIMEOUT, counters and halt_pc SHALL hold; done SHALL be high for exactly one cycle per run.
REQ-032 The latency from the qualifying input cycle to the status change SHALL be one clock.

Reset
REQ-033 When reset_n=0, the block SHALL asynchronously force IDLE, clear all outputs and counters to 0, and clear the valid flag.
REQ-034 Reset asserted mid-RUN SHALL abort the run with no done pulse.
REQ-035 After reset release, the block SHALL wait in IDLE for start.

Structure
REQ-036 The state enum and default parameter constants SHALL live in the shared package exec_monitor_pkg.
REQ-037 One sub-module, sat_counter (parametrised width, clear, enable), SHALL be instantiated for each of the three statistics counters.

Verification
REQ-038 The bench SHALL drive start, then pc sequence 0,1,2,3 with FETCH_STATE entries, then pc held at 3 in fetch for 5 cycles, and SHALL check that HALTED is reached, halt_pc=3, done pulses once and timed_out=0.
REQ-039 The bench SHALL set TIMEOUT_CYCLES=20 with pc incrementing every cycle and SHALL check timed_out=1 and cycle_count=20.
REQ-040 The bench SHALL hold pc constant from the first RUN cycle with STALL_CYCLES=5 and SHALL check that halt occurs only after 5 valid compare cycles (cycle_count=6).
REQ-041 The bench SHALL configure halt and timeout to qualify on the same cycle and SHALL check halted=1, timed_out=0.
REQ-042 The bench SHALL pulse reset_n low mid-RUN and SHALL check IDLE with all outputs 0; a following start SHALL run normally.
REQ-043 The bench SHALL set COUNT_WIDTH=4 with 20 mem_write cycles and SHALL check write_count saturates at 15.
